// File: rtl/uart_tx_buffer_if.sv
// Host/UART_TX-facing signal bundle of the transmit byte buffer.
// The master side is the surrounding logic (host writer plus UART_TX busy flag).
interface uart_tx_buffer_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_en;
  logic                   flush;
  logic [ADDRESS_WIDTH:0] buf_count;
  logic                   buf_empty;
  logic                   buf_full;
  logic                   wr_overflow;
  logic [DATA_WIDTH-1:0]  tx_data;
  logic                   tx_rdy;
  logic                   tx_busy;

  modport master (
    output wr_data, wr_en, flush, tx_busy,
    input  buf_count, buf_empty, buf_full, wr_overflow, tx_data, tx_rdy
  );

  modport slave (
    input  wr_data, wr_en, flush, tx_busy,
    output buf_count, buf_empty, buf_full, wr_overflow, tx_data, tx_rdy
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// Transmit byte buffer: circular RAM filled by host strobes, drained one byte
// at a time into UART_TX through the tx_data/tx_rdy/tx_busy handshake.
module uart_tx_buffer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_buffer_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                   state;
  logic [DATA_WIDTH-1:0]    ram [DEPTH];
  logic [DATA_WIDTH-1:0]    rd_q;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_nxt;
  logic                     full;
  logic                     empty;
  logic                     wr_accept;
  logic                     pop;

  // Full/empty decisions always use the current-cycle count.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign wr_accept = bus.wr_en && !bus.flush && !full;
  assign pop       = (state == IDLE) && !empty && !bus.tx_busy && !bus.flush;

  always_comb begin
    count_nxt = count;
    if (bus.flush)
      count_nxt = '0;
    else if (wr_accept && !pop)
      count_nxt = count + CNT_W'(1);
    else if (!wr_accept && pop)
      count_nxt = count - CNT_W'(1);
  end

  assign bus.buf_count = count;

  // Pointers, occupancy flags and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.buf_empty   <= 1'b1;
      bus.buf_full    <= 1'b0;
      bus.wr_overflow <= 1'b0;
    end else begin
      count         <= count_nxt;
      bus.buf_empty <= (count_nxt == '0);
      bus.buf_full  <= (count_nxt == CNT_W'(DEPTH));
      if (bus.flush) begin
        wr_ptr          <= '0;
        rd_ptr          <= '0;
        bus.wr_overflow <= 1'b0;
      end else begin
        if (wr_accept)
          wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
        if (pop)
          rd_ptr <= rd_ptr + ADDRESS_WIDTH'(1);
        // A dropped write wins over a same-cycle pop clearing the flag.
        if (bus.wr_en && full)
          bus.wr_overflow <= 1'b1;
        else if (pop)
          bus.wr_overflow <= 1'b0;
      end
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_accept)
      ram[wr_ptr] <= bus.wr_data;
    if (pop)
      rd_q <= ram[rd_ptr];
  end

  // Drain sequencer; tx_rdy is high exactly while in WAIT_BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bus.tx_data <= '0;
      bus.tx_rdy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop)
            state <= LOAD;
        end
        LOAD: begin
          bus.tx_data <= rd_q;
          bus.tx_rdy  <= 1'b1;
          state       <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            bus.tx_rdy <= 1'b0;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy)
            state <= IDLE;
        end
        default: begin
          bus.tx_rdy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a simple UART_TX busy model.
module tb_uart_tx_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_tx_buffer_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8)) bus ();

  uart_tx_buffer #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // UART_TX model state
  logic      model_busy = 1'b0;
  logic      force_busy = 1'b0;
  int        model_dly  = 0;
  int        model_bcnt = 0;
  int        rdy_while_busy = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  assign bus.tx_busy = model_busy | force_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Wait until buffer empty and handshake quiet for several cycles.
  task automatic wait_drain(input int budget, input string tag);
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < budget) begin
      tick();
      n++;
      if (bus.buf_empty && !bus.tx_rdy && !bus.tx_busy && model_dly == 0)
        stable++;
      else
        stable = 0;
    end
    if (stable < 4)
      check({tag, "_timeout"}, 32'(n), 32'(budget + 1));
  endtask

  task automatic compare_queues(input string tag);
    int nbad = 0;
    check({tag, "_size"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) nbad++;
    check({tag, "_order"}, 32'(nbad), 32'(0));
  endtask

  // UART_TX model: busy rises 2 cycles after tx_rdy is seen and lasts 20 cycles.
  initial begin
    forever begin
      tick();
      if (!rst) begin
        model_busy = 1'b0;
        model_dly  = 0;
        model_bcnt = 0;
      end else if (model_bcnt > 0) begin
        model_bcnt--;
        if (model_bcnt == 0) model_busy = 1'b0;
      end else if (model_dly > 0) begin
        model_dly--;
        if (model_dly == 0) begin
          model_busy = 1'b1;
          model_bcnt = 20;
        end
      end else if (bus.tx_rdy) begin
        if (model_busy || force_busy) rdy_while_busy++;
        rx_q.push_back(bus.tx_data);
        model_dly = 2;
      end
    end
  end

  initial begin
    int peak;
    bus.wr_data = '0;
    bus.wr_en   = 1'b0;
    bus.flush   = 1'b0;

    // Reset
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rst_empty", 32'(bus.buf_empty), 32'(1));
    check("rst_full", 32'(bus.buf_full), 32'(0));
    check("rst_count", 32'(bus.buf_count), 32'(0));
    check("rst_rdy", 32'(bus.tx_rdy), 32'(0));
    check("rst_data", 32'(bus.tx_data), 32'(0));
    check("rst_ovf", 32'(bus.wr_overflow), 32'(0));

    // Single byte latency
    rx_q.delete();
    push(8'hA5);
    check("single_empty_e1", 32'(bus.buf_empty), 32'(0));
    check("single_rdy_e1", 32'(bus.tx_rdy), 32'(0));
    tick();
    check("single_rdy_e2", 32'(bus.tx_rdy), 32'(0));
    check("single_count_e2", 32'(bus.buf_count), 32'(0));
    tick();
    check("single_rdy_e3", 32'(bus.tx_rdy), 32'(1));
    check("single_data_e3", 32'(bus.tx_data), 32'h0A5);
    tick();
    tick();
    check("single_rdy_hold", 32'(bus.tx_rdy), 32'(1));
    tick();
    check("single_rdy_drop", 32'(bus.tx_rdy), 32'(0));
    wait_drain(200, "single");
    check("single_data_hold", 32'(bus.tx_data), 32'h0A5);
    check("single_count_end", 32'(bus.buf_count), 32'(0));
    exp_q.delete();
    exp_q.push_back(8'hA5);
    compare_queues("single");

    // Burst order
    rx_q.delete();
    exp_q.delete();
    peak = 0;
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      exp_q.push_back(8'(i));
      if (int'(bus.buf_count) > peak) peak = int'(bus.buf_count);
    end
    check("burst_peak", 32'((peak == 15 || peak == 16) ? 1 : 0), 32'(1));
    wait_drain(2000, "burst");
    compare_queues("burst");

    // Full / overflow
    rx_q.delete();
    exp_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push(8'(i));
      exp_q.push_back(8'(i));
    end
    check("full_flag", 32'(bus.buf_full), 32'(1));
    check("full_count", 32'(bus.buf_count), 32'(256));
    check("full_ovf_before", 32'(bus.wr_overflow), 32'(0));
    push(8'hEE);
    check("full_ovf_set", 32'(bus.wr_overflow), 32'(1));
    check("full_count_drop", 32'(bus.buf_count), 32'(256));
    force_busy = 1'b0;
    tick();
    check("full_ovf_clear", 32'(bus.wr_overflow), 32'(0));
    check("full_count_pop", 32'(bus.buf_count), 32'(255));
    check("full_flag_clear", 32'(bus.buf_full), 32'(0));
    wait_drain(20000, "full");
    check("full_first", 32'((rx_q.size() > 0) ? rx_q[0] : 8'hFF), 32'(0));
    compare_queues("full");

    // Wrap-around: 300 bytes in groups of 10
    rx_q.delete();
    exp_q.delete();
    for (int g = 0; g < 30; g++) begin
      for (int k = 0; k < 10; k++) begin
        push(8'((g * 10 + k) * 7 + 3));
        exp_q.push_back(8'((g * 10 + k) * 7 + 3));
      end
      wait_drain(1000, "wrap");
    end
    compare_queues("wrap");
    check("wrap_ovf", 32'(bus.wr_overflow), 32'(0));

    // Flush during WAIT_BUSY of byte 0
    rx_q.delete();
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
    check("flush_rdy_before", 32'(bus.tx_rdy), 32'(1));
    check("flush_count_before", 32'(bus.buf_count), 32'(4));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_count", 32'(bus.buf_count), 32'(0));
    check("flush_empty", 32'(bus.buf_empty), 32'(1));
    wait_drain(500, "flush");
    exp_q.delete();
    exp_q.push_back(8'h30);
    compare_queues("flush");

    // Async reset mid-WAIT_BUSY
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    check("arst_rdy_before", 32'(bus.tx_rdy), 32'(1));
    rst = 1'b0;
    #1;
    check("arst_rdy", 32'(bus.tx_rdy), 32'(0));
    check("arst_data", 32'(bus.tx_data), 32'(0));
    check("arst_count", 32'(bus.buf_count), 32'(0));
    check("arst_empty", 32'(bus.buf_empty), 32'(1));
    check("arst_full", 32'(bus.buf_full), 32'(0));
    check("arst_ovf", 32'(bus.wr_overflow), 32'(0));
    tick();
    tick();
    rst = 1'b1;
    rx_q.delete();
    wait_drain(200, "arst");
    check("arst_no_tx", 32'(rx_q.size()), 32'(0));

    check("rdy_while_busy", 32'(rdy_while_busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
